skid_pipeline: RTL
==================

# skid_pipeline

- Parametrised, full-throughput elastic pipeline: a chain of `DEPTH` skid-buffer stages between a valid/ready producer and consumer.
- Each stage registers both the forward path (data, valid) and the backward path (ready). Long ready chains are therefore cut at every stage, unlike a single register slice, whose ready is combinational from downstream.
- Adds a synchronous flush and an optional occupancy count.
- Sits on long-haul streaming paths between compute blocks and wherever timing closure needs ready to be registered.

## Interface
- `DATA_WIDTH`, 32: payload width in bits.
- `DEPTH`, 2: number of skid stages; legal range 1..16.
- `OCC_WIDTH`, derived `$clog2(2*DEPTH+1)`: occupancy width; do not override.

- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: reset, asynchronous assertion, active-low.
- `flush` in 1: synchronous clear of all stages.
- `data_in_data` in `DATA_WIDTH`: upstream payload.
- `data_in_valid` in 1: upstream valid.
- `data_in_ready` out 1: registered ready to upstream.
- `data_out_data` out `DATA_WIDTH`: downstream payload.
- `data_out_valid` out 1: downstream valid.
- `data_out_ready` in 1: downstream ready.
- `occupancy` out `OCC_WIDTH`: entries held, 0..2*DEPTH. Present only with the macro below.

## Operation
- A stage holds a main register (M) and a skid register (S).
- Stage state is EMPTY (M invalid), BUSY (M valid, S invalid) or FULL (both valid).
- A transfer occurs on an edge where valid and ready are both high. Valid must not depend on ready.
- Stage output valid = state != EMPTY; output data = M. Stage input ready = registered flag, high iff state != FULL.

State transitions (stage view; `in` = accept, `out` = downstream accepts):
- EMPTY: `in` → M<=in, BUSY; otherwise stay.
- BUSY, `in`&`out`: M<=in, stay BUSY.
- BUSY, `in`&!`out`: S<=in, FULL.
- BUSY, !`in`&`out`: EMPTY.
- BUSY, neither: stay.
- FULL: input ready=0. `out` → M<=S, BUSY; otherwise stay.

Other rules:
- Stage k output feeds stage k+1 input. The last stage drives `data_out_*`; stage 0 drives `data_in_ready`.
- Order is strictly FIFO; data is never duplicated or dropped except by flush.
- `flush` has priority over every other event: all stages go EMPTY at the next edge, and any beat handshaken on that edge is discarded.
- Ready flags reload to 1 on the flush edge. `data_in_ready` stays high through flush unless rst is asserted.
- M and S data registers are not reset. Only state and ready flags are reset.

## Timing
- On reset, all stages are EMPTY. `data_out_valid`=0, `data_in_ready`=0, `occupancy`=0. `data_out_data` is don't-care while valid=0.
- `data_in_ready` rises on the first rising edge after rst deasserts.
- Reset asserted mid-transfer discards all held beats immediately (asynchronous).
- Latency is `DEPTH` cycles from input handshake to `data_out_valid`, with no backpressure.
- Throughput is 1 beat/cycle sustained under continuous `data_out_ready`=1.
- Backpressure on `data_out_ready` reaches `data_in_ready` after `DEPTH` edges at the earliest.
- Up to 2*`DEPTH` beats are absorbed without loss; `data_in_ready` falls only when stage 0 is FULL.
- `data_in_ready` and `data_out_valid` are direct flop outputs, with no combinational input-to-output path.

## Configuration
- `SKID_PIPELINE_OCCUPANCY_EN` defined: the `occupancy` port and counter exist.
  - Counter +1 on an input handshake, −1 on an output handshake, unchanged when both occur on the same edge.
  - Reset and flush set it to 0. Flush overrides a simultaneous handshake.
  - It must equal the sum of stage populations at all times.
- Macro undefined: no `occupancy` port and no counter logic. Handshake behaviour is identical.

## Structure
- Shared package `skid_pipeline_pkg` holds:
  - `skid_state_e` enum {EMPTY, BUSY, FULL};
  - function `occ_width(depth)`.
- Sub-module `skid_stage`: one stage (M, S, state, ready flag, flush), instantiated `DEPTH` times by a generate loop.
- The top level holds the inter-stage wiring and the optional occupancy counter.

## Test plan
- Reset release, `DEPTH`=2: ready 0 during reset, 1 after the first edge.
  - Stream 0x1..0x10 with out_ready=1: outputs 0x1..0x10 in order.
  - First valid appears 2 cycles after the first accept; no bubbles.
- Hold out_ready=0, drive valid continuously, `DEPTH`=2: exactly 4 beats accepted, then ready=0, occupancy=4.
  - Release out_ready: all 4 beats emerge in order, then the stream resumes.
- Random valid/out_ready at 50% each for 10k beats, `DEPTH`=3: scoreboard shows no loss or duplication.
  - Valid is held stable while stalled; occupancy always matches the model.
- Flush with 3 beats held and a handshake on the same edge: next cycle out_valid=0, occupancy=0, ready=1.
  - The flushed beats never appear.
- Assert rst mid-stream with 2 beats held: out_valid drops immediately, before the clock.
  - After release, the next accepted value 0xAB is the first output.
- `DEPTH`=1 with the macro undefined: sustained 1 beat/cycle, 2-beat absorption, build has no `occupancy` port.

Source files
------------

// File: rtl/skid_pipeline_pkg.sv
// Shared types and helpers for the skid_pipeline elastic pipeline.
package skid_pipeline_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage

// File: rtl/skid_stage.sv
// One skid-buffer stage: main (M) and skid (S) registers with registered valid and ready.
module skid_stage
    import skid_pipeline_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    skid_state_e           state;
    logic [DATA_WIDTH-1:0] m_q;
    logic [DATA_WIDTH-1:0] s_q;
    logic                  ready_q;
    logic                  valid_q;
    logic                  in_fire;
    logic                  out_fire;

    assign in_fire   = in_valid & ready_q;
    assign out_fire  = valid_q & out_ready;
    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_data  = m_q;

    // valid_q / ready_q track the next state so both leave the stage straight from a flop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= EMPTY;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
        end else if (flush) begin
            state   <= EMPTY;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    ready_q <= 1'b1;
                    if (in_fire) begin
                        state   <= BUSY;
                        valid_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (in_fire && !out_fire) begin
                        state   <= FULL;
                        ready_q <= 1'b0;
                    end else if (!in_fire && out_fire) begin
                        state   <= EMPTY;
                        valid_q <= 1'b0;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state   <= BUSY;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        case (state)
            EMPTY: if (in_fire) m_q <= in_data;
            BUSY: begin
                if (in_fire) begin
                    if (out_fire) m_q <= in_data;
                    else          s_q <= in_data;
                end
            end
            FULL:    if (out_fire) m_q <= s_q;
            default: ;
        endcase
    end

endmodule

// File: rtl/skid_pipeline.sv
// Chain of DEPTH skid stages with registered ready at every stage.
// Optional occupancy counter enabled by SKID_PIPELINE_OCCUPANCY_EN.
module skid_pipeline
    import skid_pipeline_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 2,
    parameter int unsigned OCC_WIDTH  = occ_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] data_in_data,
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] data_out_data,
    output logic                  data_out_valid,
    input  logic                  data_out_ready
`ifdef SKID_PIPELINE_OCCUPANCY_EN
    ,
    output logic [OCC_WIDTH-1:0]  occupancy
`endif
);

    if (DEPTH < 1 || DEPTH > 16) begin : g_bad_depth
        $error("skid_pipeline: DEPTH must be within 1..16");
    end
    if (OCC_WIDTH != occ_width(DEPTH)) begin : g_bad_occ
        $error("skid_pipeline: OCC_WIDTH is derived from DEPTH and must not be overridden");
    end

    // Element k is the link into stage k; element DEPTH is the pipeline output.
    logic [DATA_WIDTH-1:0] link_data  [DEPTH+1];
    logic                  link_valid [DEPTH+1];
    logic                  link_ready [DEPTH+1];

    assign link_data[0]      = data_in_data;
    assign link_valid[0]     = data_in_valid;
    assign data_in_ready     = link_ready[0];
    assign data_out_data     = link_data[DEPTH];
    assign data_out_valid    = link_valid[DEPTH];
    assign link_ready[DEPTH] = data_out_ready;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        skid_stage #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .in_data  (link_data[k]),
            .in_valid (link_valid[k]),
            .in_ready (link_ready[k]),
            .out_data (link_data[k+1]),
            .out_valid(link_valid[k+1]),
            .out_ready(link_ready[k+1])
        );
    end

`ifdef SKID_PIPELINE_OCCUPANCY_EN
    logic                 in_hs;
    logic                 out_hs;
    logic [OCC_WIDTH-1:0] occ_q;

    assign in_hs     = data_in_valid & data_in_ready;
    assign out_hs    = data_out_valid & data_out_ready;
    assign occupancy = occ_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q <= '0;
        end else if (flush) begin
            occ_q <= '0;
        end else if (in_hs && !out_hs) begin
            occ_q <= occ_q + OCC_WIDTH'(1);
        end else if (!in_hs && out_hs) begin
            occ_q <= occ_q - OCC_WIDTH'(1);
        end
    end
`endif

endmodule
